// File: rtl/task2.sv
// ARC4 key-scheduling engine: fills a 256-byte state RAM with the identity
// permutation, then runs the KSA swap loop using a 24-bit key taken from SW.
module task2_ram (
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] q
);
    logic [7:0] mem [0:255];

    // NOTE: the memory array is deliberately not reset; INIT rewrites every location.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        q <= mem[addr];
    end
endmodule

module task2 (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    typedef enum logic [2:0] {
        INIT, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, DONE
    } state_t;

    logic       rst;
    logic       unused_keys;
    state_t     state, state_n;
    logic [7:0] i, i_n, j, j_n, si, si_n, sj, sj_n;
    logic [1:0] kidx, kidx_n;
    logic       done, done_n;
    logic [23:0] key;
    logic [7:0] key_byte;
    logic [7:0] addr, wdata, q;
    logic       we;

    assign rst         = KEY[3];
    assign unused_keys = ^KEY[2:0];

    task2_ram s (
        .clk   (CLOCK_50),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .q     (q)
    );

    // kidx tracks i mod 3, so byte 0 is the most significant key byte.
    always_comb begin
        case (kidx)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    end

    // NOTE: every combinational output gets a default first, so no latches are inferred.
    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        si_n    = si;
        sj_n    = sj;
        kidx_n  = kidx;
        done_n  = done;
        addr    = i;
        wdata   = i;
        we      = 1'b0;

        case (state)
            INIT: begin
                we  = 1'b1;
                i_n = i + 8'd1;
                if (i == 8'hFF) begin
                    j_n     = 8'd0;
                    kidx_n  = 2'd0;
                    state_n = RD_SI;
                end
            end
            RD_SI: state_n = WT_SI;
            WT_SI: begin
                si_n    = q;
                j_n     = j + q + key_byte;
                state_n = RD_SJ;
            end
            RD_SJ: begin
                addr    = j;
                state_n = WT_SJ;
            end
            WT_SJ: begin
                addr    = j;
                sj_n    = q;
                state_n = WR_SI;
            end
            WR_SI: begin
                we      = 1'b1;
                wdata   = sj;
                state_n = WR_SJ;
            end
            WR_SJ: begin
                we    = 1'b1;
                addr  = j;
                wdata = si;
                if (i == 8'hFF) begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    i_n     = i + 8'd1;
                    kidx_n  = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    state_n = RD_SI;
                end
            end
            DONE:    done_n  = 1'b1;
            default: state_n = INIT;
        endcase

        // Reset may land in any state; it must never let a write through.
        if (rst)
            we = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state <= INIT;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            kidx  <= 2'd0;
            done  <= 1'b0;
            key   <= {14'b0, SW};
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            si    <= si_n;
            sj    <= sj_n;
            kidx  <= kidx_n;
            done  <= done_n;
        end
    end

    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign LEDR = {9'b0, done};
endmodule

// File: tb/tb_task2.sv
// Directed bench for task2: exact INIT/KSA timing, intermediate swaps, final
// state against a software KSA, mid-run reset and SW insensitivity.
module tb_task2;
    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY      = 4'b1000;
    logic [9:0] SW       = 10'h000;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int checks = 0;
    int errors = 0;
    int bad_out = 0;
    logic [7:0] ref_s [0:255];

    task2 dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Blank displays and unused LEDs are watched on every falling edge.
    always @(negedge CLOCK_50) begin
        if ({HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} != {6{7'h7F}} || LEDR[9:1] != 9'b0)
            bad_out++;
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on falling edges.
    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic build_ref(input logic [23:0] k);
        logic [7:0] kb [0:2];
        logic [7:0] jj, t;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            jj = jj + ref_s[n] + kb[n % 3];
            t = ref_s[n];
            ref_s[n] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    task automatic do_reset(input logic [9:0] sw, input int cycles);
        @(negedge CLOCK_50);
        KEY[3] = 1'b1;
        SW     = sw;
        tick(cycles);
        KEY[3] = 1'b0;
    endtask

    task automatic check_final(input string tag, input logic [23:0] k);
        int mism = 0;
        build_ref(k);
        for (int n = 0; n < 256; n++)
            if (dut.s.mem[n] !== ref_s[n]) mism++;
        check(tag, mism, 0);
    endtask

    // Time from release to done must be exactly 1792 rising edges.
    task automatic check_done_timing(input string tag, input int already);
        tick(1791 - already);
        check({tag, "_done_early"}, int'(LEDR[0]), 0);
        tick(1);
        check({tag, "_done_at_1792"}, int'(LEDR[0]), 1);
    endtask

    initial begin
        int cnt;
        logic [255:0] seen;

        // Run A: SW=0x018, two reset cycles.
        do_reset(10'h018, 2);
        check("reset_ledr", int'(LEDR), 0);
        check("reset_key", int'(dut.key), 24'h000018);
        cnt = 0;
        for (int n = 0; n < 256; n++) begin
            tick(1);
            if (LEDR[0] !== 1'b0) cnt++;
        end
        check("init_done_low", cnt, 0);
        cnt = 0;
        for (int n = 0; n < 256; n++)
            if (dut.s.mem[n] !== 8'(n)) cnt++;
        check("init_identity", cnt, 0);
        // SW wiggles after release must not matter.
        SW = 10'h2A5;
        tick(18);
        check("iter2_s2", int'(dut.s.mem[2]), 8'h1B);
        check("iter2_s27", int'(dut.s.mem[27]), 8'h02);
        check("iter2_s0", int'(dut.s.mem[0]), 8'h00);
        check("iter2_s1", int'(dut.s.mem[1]), 8'h01);
        SW = 10'h155;
        check_done_timing("runA", 256 + 18);
        check_final("runA_final", 24'h000018);
        check("runA_key_held", int'(dut.key), 24'h000018);
        tick(20);
        check("runA_done_holds", int'(LEDR[0]), 1);
        check_final("runA_final_stable", 24'h000018);

        // Run B: SW=0, permutation check.
        do_reset(10'h000, 1);
        check("runB_done_cleared", int'(LEDR[0]), 0);
        check_done_timing("runB", 0);
        check_final("runB_final", 24'h000000);
        seen = '0;
        for (int n = 0; n < 256; n++) seen[dut.s.mem[n]] = 1'b1;
        check("runB_permutation", int'($countones(seen)), 256);

        // Run C: reset in the middle of KSA with a new key.
        do_reset(10'h018, 2);
        tick(900);
        check("runC_mid_not_done", int'(LEDR[0]), 0);
        do_reset(10'h3FF, 1);
        check("runC_key", int'(dut.key), 24'h0003FF);
        check("runC_ledr_after_reset", int'(LEDR), 0);
        check_done_timing("runC", 0);
        check_final("runC_final", 24'h0003FF);

        check("outputs_static", bad_out, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/task2.md
TASK2 -- requirements
Module: task2

Interface
REQ-001 Clock and reset: one clock, CLOCK_50; reset is synchronous and active-high. The reset port is KEY[3], named as the codebase names it. The polarity and synchronicity are fixed.
REQ-002 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 KEY  input  4  KEY[3] is the reset; KEY[2:0] SHALL be ignored.
REQ-004 SW  input  10  low 10 bits of the 24-bit ARC4 key.
REQ-005 HEX0..HEX5  output  7 each  seven-segment displays, active-low segments.
REQ-006 LEDR  output  10  LEDR[0] is the done flag; LEDR[9:1] are tied to 0.

Function
REQ-007 Internal state: one 256x8 single-port RAM instance named s.
  - Synchronous write; read data valid one cycle after the address is presented.
  - Hierarchically readable by the verification bench.
REQ-008 Internal 24-bit register named key.
  - Loaded with {14'b0, SW[9:0]} on every cycle that reset is high.
  - Held constant otherwise.
  - Key byte k SHALL be: k=0 key[23:16], k=1 key[15:8], k=2 key[7:0].
REQ-009 State machine states: INIT, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, DONE.
REQ-010 Reset entry: reset high SHALL force state INIT, i=0, j=0, done=0, RAM write enable 0. This applies from any state, including mid-operation, and SHALL restart the whole sequence.
REQ-011 INIT: write s[i]=i and increment i once per cycle.
  - After writing i=255, i wraps to 0, j is 0, go to RD_SI.
  - INIT SHALL take exactly 256 cycles.
REQ-012 RD_SI: present address i, no write. Go to WT_SI.
REQ-013 WT_SI: capture si=s[i]; set j = (j + si + key byte (i mod 3)) mod 256, 8-bit wrapping add. Go to RD_SJ.
REQ-014 RD_SJ: present address j. Go to WT_SJ.
REQ-015 WT_SJ: capture sj=s[j]. Go to WR_SI.
REQ-016 WR_SI: write s[i]=sj. Go to WR_SJ.
REQ-017 WR_SJ: write s[j]=si.
  - If i=255 go to DONE.
  - Otherwise increment i and go to RD_SI.
REQ-018 When i=j the two writes store the same value, so s is unchanged; no special case SHALL be needed.
REQ-019 Each KSA iteration SHALL take exactly 6 cycles. done SHALL rise exactly 256 + 256*6 = 1792 cycles after the first cycle with reset low.
REQ-020 i mod 3 SHALL be tracked by a 2-bit counter (0,1,2,0,...) reset to 0 at the start of KSA; no divider.
REQ-021 DONE: no RAM writes; done=1 (LEDR[0]=1); remain in DONE until reset.
REQ-022 SW changes after reset release SHALL have no effect until the next reset.

Reset
REQ-023 Reset values:
  - state INIT, i=0, j=0, done=0, LEDR=10'b0.
  - HEX0..HEX5 = 7'b1111111 (blank) at all times.
REQ-024 RAM contents SHALL NOT be cleared by reset; INIT rewrites all 256 locations.

Verification
REQ-025 Reset 2 cycles with SW=10'h018, then release:
  - key=24'h000018.
  - After 256 cycles s[k]=k for all k.
  - LEDR[0]=0 throughout INIT.
REQ-026 SW=10'h018 run to done:
  - After iteration i=2: s[2]=8'h1B, s[27]=8'h02 (j sequence 0, 1, 0x1B).
  - LEDR[0]=1 at cycle 1792.
  - Final s equals a software ARC4 KSA with key 00 00 18.
REQ-027 SW=0 run to done:
  - Final s matches the KSA reference for key 00 00 00.
  - s is a permutation of 0..255.
REQ-028 Reset asserted mid-KSA (cycle ~900) for 1 cycle with SW changed to 10'h3FF:
  - Restart from INIT; key=24'h0003FF.
  - done only at 1792 cycles after the new release.
  - Final s matches the KSA reference for key 00 03 FF.
REQ-029 Across all runs: HEX0..HEX5 stay 7'b1111111; LEDR[9:1] stay 0; SW toggled after release does not alter the final s.
